// File: rtl/prio_decoder.sv
// Buffered 2-to-4 priority decoder: 2-entry FIFO of {code, none} words feeding a
// registered one-hot / priority-mask output, plus a saturating "none" word counter.

module prio_decoder_lane #(
  parameter int LANE      = 0,
  parameter bit MASK_MODE = 1'b0
) (
  input  logic [1:0] code,
  input  logic       none,
  input  logic       valid,
  output logic       sel
);
  localparam logic [1:0] IDX = 2'(LANE);

  // Mask mode lights this line for any code at or above it.
  assign sel = valid && !none && (MASK_MODE ? (code >= IDX) : (code == IDX));
endmodule

module prio_decoder #(
  parameter bit MASK_MODE = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       y,
  output logic             out_none,
  output logic [CNT_W-1:0] none_cnt
);
  typedef struct packed {
    logic [1:0] code;
    logic       none;
  } entry_t;

  entry_t [1:0] mem;
  logic         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [1:0]   count, count_nxt;
  logic         push, pop, valid_nxt;
  entry_t       in_word, head_nxt;
  logic [3:0]   y_nxt;

  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign in_word  = '{code: in_code, none: in_none};

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    rd_ptr_nxt = pop ? ~rd_ptr : rd_ptr;
    // The new head may be the word being written this very edge (empty FIFO, or
    // push+pop at one entry), so forward it rather than read the stale slot.
    head_nxt = mem[rd_ptr_nxt];
    if (push && (wr_ptr == rd_ptr_nxt))
      head_nxt = in_word;
    valid_nxt = (count_nxt != 2'd0);
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    prio_decoder_lane #(.LANE(i), .MASK_MODE(MASK_MODE)) u_lane (
      .code  (head_nxt.code),
      .none  (head_nxt.none),
      .valid (valid_nxt),
      .sel   (y_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      out_valid <= 1'b0;
      y         <= 4'b0000;
      out_none  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_word;
        wr_ptr      <= ~wr_ptr;
      end
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= valid_nxt;
      y         <= y_nxt;
      out_none  <= valid_nxt && head_nxt.none;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      none_cnt <= '0;
    else if (push && in_none && (none_cnt != {CNT_W{1'b1}}))
      none_cnt <= none_cnt + 1'b1;
  end
endmodule

// File: tb/tb_prio_decoder.sv
// Directed table-driven bench: one-hot DUT (CNT_W=2, to reach saturation) and
// mask DUT (CNT_W=8) share stimulus; expected values are hand-computed per row.

module tb_prio_decoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, in_none;
  logic [1:0] in_code;
  logic       in_ready0, in_ready1, out_valid0, out_valid1, out_none0, out_none1;
  logic [3:0] y0, y1;
  logic [1:0] none_cnt0;
  logic [7:0] none_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_decoder #(.MASK_MODE(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_code(in_code), .in_none(in_none), .out_valid(out_valid0),
    .out_ready(out_ready), .y(y0), .out_none(out_none0), .none_cnt(none_cnt0)
  );

  prio_decoder #(.MASK_MODE(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_code(in_code), .in_none(in_none), .out_valid(out_valid1),
    .out_ready(out_ready), .y(y1), .out_none(out_none1), .none_cnt(none_cnt1)
  );

  typedef struct {
    logic       v;
    logic [1:0] code;
    logic       none;
    logic       ordy;
    logic       e_ov;
    logic [3:0] e_y0;
    logic [3:0] e_y1;
    logic       e_none;
    logic       e_ir;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [1:0] code, logic none, logic ordy,
                              logic e_ov, logic [3:0] e_y0, logic [3:0] e_y1,
                              logic e_none, logic e_ir, logic [7:0] e_c0, logic [7:0] e_c1);
    vec_t r;
    r.v = v; r.code = code; r.none = none; r.ordy = ordy;
    r.e_ov = e_ov; r.e_y0 = e_y0; r.e_y1 = e_y1; r.e_none = e_none;
    r.e_ir = e_ir; r.e_c0 = e_c0; r.e_c1 = e_c1;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic ov, input logic [3:0] ey0, input logic [3:0] ey1,
                         input logic en, input logic ir, input logic [7:0] c0, input logic [7:0] c1);
    chk("out_valid0", idx, 32'(out_valid0), 32'(ov));
    chk("out_valid1", idx, 32'(out_valid1), 32'(ov));
    chk("y_onehot",   idx, 32'(y0),         32'(ey0));
    chk("y_mask",     idx, 32'(y1),         32'(ey1));
    chk("out_none0",  idx, 32'(out_none0),  32'(en));
    chk("out_none1",  idx, 32'(out_none1),  32'(en));
    chk("in_ready0",  idx, 32'(in_ready0),  32'(ir));
    chk("in_ready1",  idx, 32'(in_ready1),  32'(ir));
    chk("none_cnt0",  idx, 32'(none_cnt0),  32'(c0));
    chk("none_cnt1",  idx, 32'(none_cnt1),  32'(c1));
  endtask

  task automatic drive(input logic v, input logic [1:0] code, input logic none, input logic ordy);
    in_valid = v; in_code = code; in_none = none; out_ready = ordy;
  endtask

  initial begin
    //                v  code  n  ordy ov  y0       y1       n  ir c0 c1
    vecs[0]  = mk(1, 2'd0, 0, 1,  1, 4'b0001, 4'b0001, 0, 1, 0, 0);
    vecs[1]  = mk(1, 2'd1, 0, 1,  1, 4'b0010, 4'b0011, 0, 1, 0, 0);
    vecs[2]  = mk(1, 2'd2, 0, 1,  1, 4'b0100, 4'b0111, 0, 1, 0, 0);
    vecs[3]  = mk(1, 2'd3, 0, 1,  1, 4'b1000, 4'b1111, 0, 1, 0, 0);
    vecs[4]  = mk(0, 2'd0, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    // backpressure: two words fill the FIFO, third is refused until a pop
    vecs[5]  = mk(1, 2'd2, 0, 0,  1, 4'b0100, 4'b0111, 0, 1, 0, 0);
    vecs[6]  = mk(1, 2'd1, 0, 0,  1, 4'b0100, 4'b0111, 0, 0, 0, 0);
    vecs[7]  = mk(1, 2'd3, 0, 0,  1, 4'b0100, 4'b0111, 0, 0, 0, 0);
    vecs[8]  = mk(1, 2'd3, 0, 1,  1, 4'b0010, 4'b0011, 0, 1, 0, 0);
    vecs[9]  = mk(1, 2'd3, 0, 1,  1, 4'b1000, 4'b1111, 0, 1, 0, 0);
    vecs[10] = mk(0, 2'd0, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    // push/pop at one entry
    vecs[11] = mk(1, 2'd3, 0, 1,  1, 4'b1000, 4'b1111, 0, 1, 0, 0);
    vecs[12] = mk(1, 2'd0, 0, 1,  1, 4'b0001, 4'b0001, 0, 1, 0, 0);
    vecs[13] = mk(1, 2'd3, 0, 1,  1, 4'b1000, 4'b1111, 0, 1, 0, 0);
    vecs[14] = mk(0, 2'd0, 0, 1,  0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    // none words; CNT_W=2 saturates at 3
    vecs[15] = mk(1, 2'd3, 1, 0,  1, 4'b0000, 4'b0000, 1, 1, 1, 1);
    vecs[16] = mk(1, 2'd3, 1, 1,  1, 4'b0000, 4'b0000, 1, 1, 2, 2);
    vecs[17] = mk(1, 2'd1, 1, 1,  1, 4'b0000, 4'b0000, 1, 1, 3, 3);
    vecs[18] = mk(1, 2'd2, 1, 1,  1, 4'b0000, 4'b0000, 1, 1, 3, 4);
    vecs[19] = mk(1, 2'd0, 1, 1,  1, 4'b0000, 4'b0000, 1, 1, 3, 5);
    vecs[20] = mk(0, 2'bxx, 1'bx, 1, 0, 4'b0000, 4'b0000, 0, 1, 3, 5);
    vecs[21] = mk(1, 2'd1, 0, 0,  1, 4'b0010, 4'b0011, 0, 1, 3, 5);

    rst_n = 1'b0;
    drive(0, 2'd0, 0, 0);
    #1;
    chk_all(-1, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].code, vecs[i].none, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_ov, vecs[i].e_y0, vecs[i].e_y1, vecs[i].e_none,
              vecs[i].e_ir, vecs[i].e_c0, vecs[i].e_c1);
    end

    // second word fills the FIFO, then async reset mid-cycle
    drive(1, 2'd3, 0, 0);
    @(posedge clk);
    #1;
    chk_all(100, 1, 4'b0010, 4'b0011, 0, 0, 3, 5);
    drive(0, 2'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all(101, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 2'd0, 0, 1);
    @(posedge clk);
    #1;
    chk_all(102, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);
    // first push right after reset release shows on the next edge
    drive(1, 2'd2, 0, 1);
    @(posedge clk);
    #1;
    chk_all(103, 1, 4'b0100, 4'b0111, 0, 1, 0, 0);
    drive(0, 2'd0, 0, 1);
    @(posedge clk);
    #1;
    chk_all(104, 0, 4'b0000, 4'b0000, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
